// File: rtl/intpol2_ctrl_fsm.sv
// Control sequencer for a power-of-two polynomial interpolator: config read-in,
// per-channel prep/load/emit loop, stream refill, bypass and abort handling.
module intpol2_ctrl_fsm #(
    parameter int unsigned LOG2_D    = 2,
    parameter int unsigned NCH       = 1,
    parameter int unsigned CFG_WORDS = 3,
    parameter int unsigned ADDR_W    = 2,
    localparam int unsigned CH_W     = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              mode,
    input  logic              bypass,
    input  logic              empty,
    input  logic              afull,
    output logic              busy,
    output logic              rd_en,
    output logic              ld_data,
    output logic              wr_en,
    output logic              ld_p1_xi,
    output logic              en_sum,
    output logic              op_1,
    output logic              sel_mult,
    output logic              en_stream,
    output logic              stop_empty,
    output logic              stop_afull,
    output logic              done,
    output logic              clear,
    output logic [ADDR_W-1:0] cfg_addr,
    output logic [LOG2_D-1:0] phase,
    output logic [CH_W-1:0]   ch
);

    localparam int unsigned D = 32'd1 << LOG2_D;
    localparam logic [LOG2_D-1:0] PH_LAST   = LOG2_D'(D - 1);
    localparam logic [CH_W-1:0]   CH_LAST   = CH_W'(NCH - 1);
    localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(CFG_WORDS - 1);

    typedef enum logic [3:0] {
        S_IDLE,
        S_CFG,
        S_PREP,
        S_LOADP,
        S_EMIT,
        S_DONE,
        S_STREAM,
        S_CLEAR,
        S_BYP_STRM,
        S_BYP_ACCEL
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [ADDR_W-1:0] r_cfg_addr;
    logic [ADDR_W-1:0] w_cfg_addr_nxt;
    logic [LOG2_D-1:0] r_phase;
    logic [LOG2_D-1:0] w_phase_nxt;
    logic [CH_W-1:0]   r_ch;
    logic [CH_W-1:0]   w_ch_nxt;
    logic              r_wr_en;
    logic              w_abort;

    // State, counters and the one-cycle delayed write strobe
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_cfg_addr <= '0;
            r_phase    <= '0;
            r_ch       <= '0;
            r_wr_en    <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_cfg_addr <= w_cfg_addr_nxt;
            r_phase    <= w_phase_nxt;
            r_ch       <= w_ch_nxt;
            r_wr_en    <= ld_data;
        end
    end

    assign wr_en    = r_wr_en;
    assign cfg_addr = r_cfg_addr;
    assign phase    = r_phase;
    assign ch       = r_ch;
    assign w_abort  = start && (r_state != S_IDLE) && (r_state != S_CLEAR);

    // Next state, counter updates and per-state strobes
    always_comb begin
        w_state_nxt    = r_state;
        w_cfg_addr_nxt = r_cfg_addr;
        w_phase_nxt    = r_phase;
        w_ch_nxt       = r_ch;
        busy           = 1'b0;
        rd_en          = 1'b0;
        ld_data        = 1'b0;
        ld_p1_xi       = 1'b0;
        en_sum         = 1'b0;
        op_1           = 1'b0;
        sel_mult       = 1'b0;
        en_stream      = 1'b0;
        stop_empty     = 1'b0;
        stop_afull     = 1'b0;
        done           = 1'b0;

        unique case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_nxt = (bypass && mode) ? S_BYP_STRM : S_CFG;
                end
            end
            S_CFG: begin
                busy  = 1'b1;
                rd_en = 1'b1;
                if (mode && empty) begin
                    stop_empty = 1'b1;
                end else if (r_cfg_addr == ADDR_LAST) begin
                    w_cfg_addr_nxt = '0;
                    w_phase_nxt    = '0;
                    w_ch_nxt       = '0;
                    if (bypass) begin
                        w_state_nxt = mode ? S_BYP_STRM : S_BYP_ACCEL;
                    end else begin
                        w_state_nxt = S_PREP;
                    end
                end else begin
                    w_cfg_addr_nxt = r_cfg_addr + ADDR_W'(1);
                end
            end
            S_PREP: begin
                busy        = 1'b1;
                op_1        = 1'b1;
                w_state_nxt = S_LOADP;
            end
            S_LOADP: begin
                busy        = 1'b1;
                ld_p1_xi    = 1'b1;
                w_state_nxt = S_EMIT;
            end
            S_EMIT: begin
                busy     = 1'b1;
                sel_mult = 1'b1;
                if (mode && afull) begin
                    stop_afull = 1'b1;
                end else begin
                    ld_data = 1'b1;
                    en_sum  = (r_phase != PH_LAST);
                    if (r_phase != PH_LAST) begin
                        w_phase_nxt = r_phase + LOG2_D'(1);
                        w_state_nxt = S_LOADP;
                    end else if (r_ch != CH_LAST) begin
                        w_phase_nxt = '0;
                        w_ch_nxt    = r_ch + CH_W'(1);
                        w_state_nxt = S_PREP;
                    end else begin
                        w_phase_nxt = '0;
                        w_ch_nxt    = '0;
                        w_state_nxt = S_DONE;
                    end
                end
            end
            S_DONE: begin
                busy        = 1'b1;
                done        = 1'b1;
                w_state_nxt = mode ? S_STREAM : S_IDLE;
            end
            S_STREAM: begin
                busy       = 1'b1;
                rd_en      = 1'b1;
                en_stream  = 1'b1;
                stop_empty = empty;
                if (!empty) begin
                    w_state_nxt = S_PREP;
                end
            end
            S_CLEAR: begin
                w_cfg_addr_nxt = '0;
                w_phase_nxt    = '0;
                w_ch_nxt       = '0;
                stop_empty     = !start && empty;
                if (!start && !empty) begin
                    w_state_nxt = S_CFG;
                end
            end
            S_BYP_STRM: begin
                busy       = 1'b1;
                stop_empty = empty;
                stop_afull = afull;
                rd_en      = !empty && !afull;
                ld_data    = !empty && !afull;
            end
            S_BYP_ACCEL: begin
                busy        = 1'b1;
                done        = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        // Abort wins over every transition; rd_en keeps its state value
        if (w_abort) begin
            w_state_nxt    = S_CLEAR;
            w_cfg_addr_nxt = '0;
            w_phase_nxt    = '0;
            w_ch_nxt       = '0;
            ld_data        = 1'b0;
            en_sum         = 1'b0;
        end

        clear = start | done;
    end

endmodule

// File: tb/tb_intpol2_ctrl_fsm.sv
// Bench for intpol2_ctrl_fsm (D=4, NCH=2, CFG_WORDS=3): position-based reference
// model checked every cycle, plus literal timing/count pins from directed runs.
module tb_intpol2_ctrl_fsm;

    localparam int D       = 4;
    localparam int NCH     = 2;
    localparam int CW      = 3;
    localparam int SEG     = 1 + 2 * D;
    localparam int DONEPOS = CW + NCH * SEG;

    localparam int W_IDLE  = 0;
    localparam int W_RUN   = 1;
    localparam int W_SWAIT = 2;
    localparam int W_CLEAR = 3;
    localparam int W_BYPS  = 4;
    localparam int W_BYPA  = 5;

    localparam int K_NONE = 0;
    localparam int K_CFG  = 1;
    localparam int K_PREP = 2;
    localparam int K_LOAD = 3;
    localparam int K_EMIT = 4;
    localparam int K_DONE = 5;

    logic       clk, rst, start, mode, bypass, empty, afull;
    logic       busy, rd_en, ld_data, wr_en, ld_p1_xi, en_sum, op_1, sel_mult;
    logic       en_stream, stop_empty, stop_afull, done, clear;
    logic [1:0] cfg_addr;
    logic [1:0] phase;
    logic [0:0] ch;

    intpol2_ctrl_fsm #(.LOG2_D(2), .NCH(2), .CFG_WORDS(3), .ADDR_W(2)) dut (
        .clk(clk), .rst(rst), .start(start), .mode(mode), .bypass(bypass),
        .empty(empty), .afull(afull), .busy(busy), .rd_en(rd_en),
        .ld_data(ld_data), .wr_en(wr_en), .ld_p1_xi(ld_p1_xi), .en_sum(en_sum),
        .op_1(op_1), .sel_mult(sel_mult), .en_stream(en_stream),
        .stop_empty(stop_empty), .stop_afull(stop_afull), .done(done),
        .clear(clear), .cfg_addr(cfg_addr), .phase(phase), .ch(ch)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int n_ld = 0;
    int n_wr = 0;
    int done_cyc = -1;

    int m_where = W_IDLE;
    int m_pos = 0;
    bit m_prevld = 1'b0;
    bit m_known = 1'b0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Reference model: a run is a linear position through config words, per-channel
    // segments (prep, then load/emit pairs) and a final done slot.
    always @(negedge clk) begin : model
        int  kind, b, o, mph, mch, mca;
        bit  e_busy, e_rd, e_ld, e_ld1, e_en, e_op1, e_sel, e_es, e_se, e_sa, e_done, e_clr;
        bit  stall, abort;
        kind = K_NONE; mph = 0; mch = 0; mca = 0; stall = 1'b0;
        e_busy = 0; e_rd = 0; e_ld = 0; e_ld1 = 0; e_en = 0; e_op1 = 0;
        e_sel = 0; e_es = 0; e_se = 0; e_sa = 0; e_done = 0;
        case (m_where)
            W_RUN: begin
                e_busy = 1'b1;
                if (m_pos < CW) begin
                    kind = K_CFG; mca = m_pos; e_rd = 1'b1; e_se = mode & empty;
                end else if (m_pos == DONEPOS) begin
                    kind = K_DONE; e_done = 1'b1;
                end else begin
                    b = m_pos - CW; mch = b / SEG; o = b % SEG;
                    if (o == 0) begin
                        kind = K_PREP; e_op1 = 1'b1;
                    end else if (o % 2 == 1) begin
                        kind = K_LOAD; e_ld1 = 1'b1; mph = (o - 1) / 2;
                    end else begin
                        kind = K_EMIT; e_sel = 1'b1; mph = (o - 2) / 2;
                        stall = mode & afull;
                        e_sa = stall; e_ld = !stall; e_en = !stall && (mph != D - 1);
                    end
                end
            end
            W_SWAIT: begin e_busy = 1; e_rd = 1; e_es = 1; e_se = empty; end
            W_CLEAR: e_se = !start & empty;
            W_BYPS: begin
                e_busy = 1; e_se = empty; e_sa = afull;
                e_rd = !empty & !afull; e_ld = e_rd;
            end
            W_BYPA: begin e_busy = 1; e_done = 1; end
            default: ;
        endcase
        abort = start && (m_where != W_IDLE) && (m_where != W_CLEAR);
        if (abort) begin e_ld = 0; e_en = 0; end
        e_clr = start | e_done;

        if (m_known) begin
            chk("busy", 32'(busy), 32'(e_busy));
            chk("rd_en", 32'(rd_en), 32'(e_rd));
            chk("ld_data", 32'(ld_data), 32'(e_ld));
            chk("wr_en", 32'(wr_en), 32'(m_prevld));
            chk("ld_p1_xi", 32'(ld_p1_xi), 32'(e_ld1));
            chk("en_sum", 32'(en_sum), 32'(e_en));
            chk("op_1", 32'(op_1), 32'(e_op1));
            chk("sel_mult", 32'(sel_mult), 32'(e_sel));
            chk("en_stream", 32'(en_stream), 32'(e_es));
            chk("stop_empty", 32'(stop_empty), 32'(e_se));
            chk("stop_afull", 32'(stop_afull), 32'(e_sa));
            chk("done", 32'(done), 32'(e_done));
            chk("clear", 32'(clear), 32'(e_clr));
            chk("cfg_addr", 32'(cfg_addr), 32'(mca));
            chk("phase", 32'(phase), 32'(mph));
            chk("ch", 32'(ch), 32'(mch));
        end
        if (ld_data === 1'b1) n_ld++;
        if (wr_en === 1'b1) n_wr++;
        if (done === 1'b1) done_cyc = cyc;

        if (rst) begin
            m_where = W_IDLE; m_pos = 0; m_prevld = 1'b0; m_known = 1'b1;
        end else begin
            m_prevld = e_ld;
            if (abort) begin
                m_where = W_CLEAR;
            end else begin
                case (m_where)
                    W_IDLE: if (start) begin
                        if (bypass && mode) m_where = W_BYPS;
                        else begin m_where = W_RUN; m_pos = 0; end
                    end
                    W_RUN: case (kind)
                        K_CFG: if (!(mode && empty)) begin
                            if (m_pos == CW - 1 && bypass) m_where = mode ? W_BYPS : W_BYPA;
                            else m_pos++;
                        end
                        K_PREP, K_LOAD: m_pos++;
                        K_EMIT: if (!stall) m_pos++;
                        K_DONE: m_where = mode ? W_SWAIT : W_IDLE;
                        default: ;
                    endcase
                    W_SWAIT: if (!empty) begin m_where = W_RUN; m_pos = CW; end
                    W_CLEAR: if (!start && !empty) begin m_where = W_RUN; m_pos = 0; end
                    W_BYPA: m_where = W_IDLE;
                    default: ;
                endcase
            end
        end
        cyc++;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit r, input bit s, input bit m, input bit b, input bit e, input bit a);
        rst = r; start = s; mode = m; bypass = b; empty = e; afull = a;
    endtask

    bit pe [8] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    bit pa [8] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};

    initial begin
        int c0;
        drive(1, 0, 0, 0, 0, 0);
        repeat (3) step();
        drive(0, 0, 0, 0, 0, 0);
        step();
        @(negedge clk);
        chk("idle_busy", 32'(busy), 32'd0);
        chk("idle_clear", 32'(clear), 32'd0);
        chk("idle_wr_en", 32'(wr_en), 32'd0);
        step();

        // Accel run, no bypass
        n_ld = 0; n_wr = 0; c0 = cyc;
        for (int r = 0; r <= 25; r++) begin
            drive(0, r == 0, 0, 0, 0, 0);
            @(negedge clk);
            if (r == 0) chk("a_clear_start", 32'(clear), 32'd1);
            if (r == 4) begin chk("a_prep0", 32'(op_1), 32'd1); chk("a_prep0_ch", 32'(ch), 32'd0); end
            if (r == 12) begin chk("a_emit_last", 32'(phase), 32'd3); chk("a_en_sum_last", 32'(en_sum), 32'd0); end
            if (r == 13) begin chk("a_prep1", 32'(op_1), 32'd1); chk("a_prep1_ch", 32'(ch), 32'd1); end
            if (r == 22) chk("a_done", 32'(done), 32'd1);
            if (r == 23) chk("a_idle", 32'(busy), 32'd0);
            step();
        end
        chk("a_ld_count", 32'(n_ld), 32'd8);
        chk("a_wr_count", 32'(n_wr), 32'd8);
        chk("a_done_cycle", 32'(done_cyc - c0), 32'd22);

        // Stream run with empty/afull stalls, refill wait, then abort in ch1 phase 3
        n_ld = 0; c0 = cyc;
        for (int r = 0; r <= 54; r++) begin
            if (r == 31) begin
                chk("s_ld_count", 32'(n_ld), 32'd8);
                chk("s_done_cycle", 32'(done_cyc - c0), 32'd30);
            end
            drive(0, (r == 0) || (r == 52), 1, 0,
                  ((r >= 2) && (r <= 4)) || ((r >= 25) && (r <= 33)),
                  (r >= 13) && (r <= 17));
            @(negedge clk);
            if (r == 3) begin chk("s_cfg_hold", 32'(cfg_addr), 32'd1); chk("s_cfg_stop", 32'(stop_empty), 32'd1); end
            if (r == 15) begin
                chk("s_afull_phase", 32'(phase), 32'd2);
                chk("s_afull_stop", 32'(stop_afull), 32'd1);
                chk("s_afull_ld", 32'(ld_data), 32'd0);
            end
            if (r == 33) begin chk("s_refill", 32'(en_stream), 32'd1); chk("s_refill_stop", 32'(stop_empty), 32'd1); end
            if (r == 35) chk("s_prep_again", 32'(op_1), 32'd1);
            if (r == 51) begin chk("s_ph3", 32'(phase), 32'd3); chk("s_ch1", 32'(ch), 32'd1); end
            if (r == 52) begin chk("s_abort_ld", 32'(ld_data), 32'd0); chk("s_abort_clear", 32'(clear), 32'd1); end
            if (r == 53) begin
                chk("s_clr_busy", 32'(busy), 32'd0);
                chk("s_clr_phase", 32'(phase), 32'd0);
                chk("s_clr_ch", 32'(ch), 32'd0);
            end
            if (r == 54) begin chk("s_cfg_busy", 32'(busy), 32'd1); chk("s_cfg_addr0", 32'(cfg_addr), 32'd0); end
            step();
        end

        drive(1, 0, 0, 0, 0, 0);
        repeat (2) step();

        // Bypass, accel
        c0 = cyc;
        for (int r = 0; r <= 6; r++) begin
            drive(0, r == 0, 0, 1, 0, 0);
            @(negedge clk);
            if (r == 3) chk("ba_cfg_last", 32'(cfg_addr), 32'd2);
            if (r == 4) chk("ba_done", 32'(done), 32'd1);
            if (r == 5) chk("ba_idle", 32'(busy), 32'd0);
            step();
        end
        chk("ba_done_cycle", 32'(done_cyc - c0), 32'd4);

        // Bypass, stream: gated pass-through, abort, clear, then reset with start
        n_ld = 0;
        for (int r = 0; r <= 17; r++) begin
            if (r == 9) chk("bs_ld_count", 32'(n_ld), 32'd3);
            if (r >= 1 && r <= 8)
                drive(0, 0, 1, 1, pe[r-1], pa[r-1]);
            else
                drive(r == 16, (r == 0) || (r == 9) || (r == 16), 1, 1, (r == 10) || (r == 17), 0);
            @(negedge clk);
            if (r == 1) chk("bs_direct", 32'(rd_en), 32'd1);
            if (r == 9) begin chk("bs_abort_rd", 32'(rd_en), 32'd1); chk("bs_abort_ld", 32'(ld_data), 32'd0); end
            if (r == 10) chk("bs_clear_stop", 32'(stop_empty), 32'd1);
            if (r == 12) chk("bs_cfg", 32'(rd_en), 32'd1);
            if (r == 17) begin chk("bs_rst_idle", 32'(stop_empty), 32'd0); chk("bs_rst_busy", 32'(busy), 32'd0); end
            step();
        end

        // Reset in the middle of an emit
        for (int r = 0; r <= 12; r++) begin
            drive(r == 10, r == 0, 0, 0, 0, 0);
            @(negedge clk);
            if (r == 10) begin chk("r_emit_ld", 32'(ld_data), 32'd1); chk("r_emit_ph", 32'(phase), 32'd2); end
            if (r == 11) begin
                chk("r_busy", 32'(busy), 32'd0);
                chk("r_wr_en", 32'(wr_en), 32'd0);
                chk("r_phase", 32'(phase), 32'd0);
                chk("r_ch", 32'(ch), 32'd0);
                chk("r_cfg_addr", 32'(cfg_addr), 32'd0);
            end
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
